// File: rtl/led_anim_pkg.sv
// Shared mode/direction encodings and the start-position helper for the LED animator.
package led_anim_pkg;

    typedef enum logic [1:0] {
        MODE_LEFT   = 2'd0,
        MODE_RIGHT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int start_pos(input mode_e m, input int n);
        return (m == MODE_RIGHT) ? n - 1 : 0;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Prescaler: counts enabled cycles and ticks once the count reaches div (>= compare).
module tick_div #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] r_cnt;

    // clr wins over a pending match so a restart never emits a stray tick
    assign tick = en && !clr && (r_cnt >= div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/led_animator.sv
// LED animation engine: step/blink timebases, head-position sequencing and LED decode.
module led_animator
    import led_anim_pkg::*;
#(
    parameter int N_LEDS  = 8,
    parameter int STEP_W  = 24,
    parameter int BLINK_W = 20,
    parameter int POS_W   = $clog2(N_LEDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [STEP_W-1:0]  step_div,
    input  logic               blink_en,
    input  logic [BLINK_W-1:0] blink_div,
    output logic [N_LEDS-1:0]  led,
    output logic [POS_W-1:0]   pos,
    output logic               step_pulse,
    output logic               wrap_pulse
);

    localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] ONE  = POS_W'(1);

    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_next;
    logic             r_dir;
    logic             w_dir_next;
    mode_e            r_mode_q;
    mode_e            w_mode_in;
    logic             r_blink_phase;
    logic             w_mode_chg;
    logic             w_step_tick;
    logic             w_blink_tick;
    logic             w_wrap;

    assign w_mode_in  = mode_e'(mode);
    assign w_mode_chg = (w_mode_in != r_mode_q);

    tick_div #(.W(STEP_W)) u_step_div (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (w_mode_chg),
        .div  (step_div),
        .tick (w_step_tick)
    );

    tick_div #(.W(BLINK_W)) u_blink_div (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .clr  (1'b0),
        .div  (blink_div),
        .tick (w_blink_tick)
    );

    always_comb begin
        w_pos_next = r_pos;
        w_dir_next = r_dir;
        w_wrap     = 1'b0;
        case (r_mode_q)
            MODE_RIGHT: begin
                w_wrap     = (r_pos == '0);
                w_pos_next = w_wrap ? LAST : r_pos - ONE;
            end
            MODE_BOUNCE: begin
                // dir holds the direction of the next move; it flips on arriving at an end
                if (r_dir == DIR_UP) begin
                    w_pos_next = (r_pos == LAST) ? LAST - ONE : r_pos + ONE;
                end else begin
                    w_pos_next = (r_pos == '0) ? ONE : r_pos - ONE;
                end
                w_wrap = (r_dir == DIR_DOWN) && (r_pos == ONE);
                if (w_pos_next == LAST) begin
                    w_dir_next = DIR_DOWN;
                end else if (w_pos_next == '0) begin
                    w_dir_next = DIR_UP;
                end
            end
            default: begin
                w_wrap     = (r_pos == LAST);
                w_pos_next = w_wrap ? '0 : r_pos + ONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos    <= '0;
            r_dir    <= DIR_UP;
            r_mode_q <= MODE_LEFT;
        end else begin
            r_mode_q <= w_mode_in;
            if (w_mode_chg) begin
                r_pos <= POS_W'(start_pos(w_mode_in, N_LEDS));
                r_dir <= DIR_UP;
            end else if (w_step_tick) begin
                r_pos <= w_pos_next;
                r_dir <= w_dir_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_phase <= 1'b1;
        end else if (w_blink_tick) begin
            r_blink_phase <= ~r_blink_phase;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LEDS; gi++) begin : g_led
            logic w_head;
            logic w_lit;
            assign w_head  = (r_pos == POS_W'(gi));
            assign w_lit   = (r_mode_q == MODE_FILL) ? (POS_W'(gi) <= r_pos) : w_head;
            assign led[gi] = w_lit & (~w_head | ~blink_en | r_blink_phase);
        end
    endgenerate

    assign pos        = r_pos;
    assign step_pulse = w_step_tick;
    assign wrap_pulse = w_step_tick & w_wrap;

endmodule

// File: tb/tb_led_animator.sv
// Directed bench for led_animator: an 8-LED and a 2-LED instance driven from shared stimulus.
module tb_led_animator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        blink_en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] step_div = 24'd3;
    logic [19:0] blink_div = 20'd0;

    logic [7:0]  led;
    logic [2:0]  pos;
    logic        step_pulse;
    logic        wrap_pulse;
    logic [1:0]  led2;
    logic        pos2;
    logic        sp2;
    logic        wp2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_animator #(.N_LEDS(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step_div(step_div),
        .blink_en(blink_en), .blink_div(blink_div),
        .led(led), .pos(pos), .step_pulse(step_pulse), .wrap_pulse(wrap_pulse)
    );

    led_animator #(.N_LEDS(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step_div(step_div),
        .blink_en(blink_en), .blink_div(blink_div),
        .led(led2), .pos(pos2), .step_pulse(sp2), .wrap_pulse(wp2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[%0t] ok %s = 0x%0h", $time, tag, got);
        end
    endtask

    int bnc[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    initial begin
        // reset state
        #2;
        check("rst_pos", 32'(pos), 0);
        check("rst_led", 32'(led), 32'h01);
        check("rst_step", 32'(step_pulse), 0);
        check("rst_wrap", 32'(wrap_pulse), 0);

        // chase-left, step every 4 cycles
        @(negedge clk);
        rst = 1'b0; en = 1'b1; mode = 2'd0; step_div = 24'd3;
        for (int j = 0; j < 36; j++) begin
            #1;
            check($sformatf("left_led_%0d", j), 32'(led), 32'(1) << ((j / 4) % 8));
            check($sformatf("left_step_%0d", j), 32'(step_pulse), 32'((j % 4) == 3));
            check($sformatf("left_wrap_%0d", j), 32'(wrap_pulse),
                  32'(((j % 4) == 3) && (((j / 4) % 8) == 7)));
            @(negedge clk);
        end

        // bounce, step every cycle; mode-change cycle must not tick
        mode = 2'd2; step_div = 24'd0;
        #1;
        check("bnc_chg_nostep", 32'(step_pulse), 0);
        @(negedge clk);
        for (int idx = 0; idx < 16; idx++) begin
            #1;
            check($sformatf("bnc_pos_%0d", idx), 32'(pos), 32'(bnc[idx]));
            check($sformatf("bnc_step_%0d", idx), 32'(step_pulse), 1);
            check($sformatf("bnc_wrap_%0d", idx), 32'(wrap_pulse), 32'(idx == 13));
            check($sformatf("bnc2_pos_%0d", idx), 32'(pos2), 32'(idx % 2));
            check($sformatf("bnc2_led_%0d", idx), 32'(led2), 32'(1) << (idx % 2));
            check($sformatf("bnc2_step_%0d", idx), 32'(sp2), 1);
            check($sformatf("bnc2_wrap_%0d", idx), 32'(wp2), 32'(idx % 2));
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        #1;
        check("bnc_pre_rst_pos", 32'(pos), 4);

        // asynchronous reset mid-run (descending through pos 4)
        rst = 1'b1; mode = 2'd0; step_div = 24'd2;
        #1;
        check("arst_pos", 32'(pos), 0);
        check("arst_led", 32'(led), 32'h01);
        check("arst_step", 32'(step_pulse), 0);
        check("arst_wrap", 32'(wrap_pulse), 0);
        check("arst_pos2", 32'(pos2), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            #1;
            check($sformatf("post_rst_step_%0d", r), 32'(step_pulse), 32'(r == 2));
            check($sformatf("post_rst_pos_%0d", r), 32'(pos), 32'(r == 3));
            @(negedge clk);
        end

        // fill-bar, step every 2 cycles
        mode = 2'd3; step_div = 24'd1;
        #1;
        check("fill_chg_nostep", 32'(step_pulse), 0);
        @(negedge clk);
        for (int k = 0; k < 18; k++) begin
            #1;
            check($sformatf("fill_led_%0d", k), 32'(led), (32'(1) << (((k / 2) % 8) + 1)) - 32'(1));
            check($sformatf("fill_step_%0d", k), 32'(step_pulse), 32'((k % 2) == 1));
            check($sformatf("fill_wrap_%0d", k), 32'(wrap_pulse),
                  32'(((k % 2) == 1) && (((k / 2) % 8) == 7)));
            @(negedge clk);
        end

        // chase-right with blink; pause for 10 cycles mid-count
        rst = 1'b1; mode = 2'd1; step_div = 24'd2; blink_en = 1'b1; blink_div = 20'd1; en = 1'b1;
        #1;
        rst = 1'b0;
        for (int s = 0; s < 21; s++) begin
            int  exp_pos;
            int  exp_led;
            logic phase;
            en = ((s < 9) || (s >= 19)) ? 1'b1 : 1'b0;
            #1;
            phase   = ((s / 2) % 2) == 0;
            exp_pos = (s == 0) ? 0 : (s <= 3) ? 7 : (s <= 6) ? 6 : (s <= 19) ? 5 : 4;
            exp_led = phase ? (1 << exp_pos) : 0;
            check($sformatf("right_pos_%0d", s), 32'(pos), 32'(exp_pos));
            check($sformatf("right_led_%0d", s), 32'(led), 32'(exp_led));
            check($sformatf("right_step_%0d", s), 32'(step_pulse), 32'((s == 3) || (s == 6) || (s == 19)));
            check($sformatf("right_wrap_%0d", s), 32'(wrap_pulse), 0);
            @(negedge clk);
        end

        // chase-left to pos 5, switch to chase-right on a would-be tick cycle
        blink_en = 1'b0; mode = 2'd0; step_div = 24'd1;
        #1;
        check("sw_chg_nostep", 32'(step_pulse), 0);
        @(negedge clk);
        for (int u = 0; u < 15; u++) begin
            int exp_pos;
            if (u == 11) mode = 2'd1;
            #1;
            exp_pos = (u <= 11) ? (u / 2) : (u < 14) ? 7 : 6;
            check($sformatf("sw_pos_%0d", u), 32'(pos), 32'(exp_pos));
            check($sformatf("sw_led_%0d", u), 32'(led), 32'(1) << exp_pos);
            check($sformatf("sw_step_%0d", u), 32'(step_pulse),
                  32'((((u % 2) == 1) && (u != 11) && (u <= 11)) || (u == 13)));
            check($sformatf("sw_wrap_%0d", u), 32'(wrap_pulse), 0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
